tdm_mux41_tx: RTL and testbench

//   Time-division 4-to-1 transmitter that feeds the 1-to-4 data distributor.
//   - Snapshots four 1-bit channel inputs once per frame.
//   - Visits each enabled channel in turn and drives its bit on oC.
//   - Drives the matching select code on oS1/oS0.
//   - Line idles high (oC=1), matching the distributor's inactive-output level.

---
 rtl/tdm_mux41_tx_if.sv | 25 ++
 rtl/tdm_mux41_tx.sv | 129 ++++++++++++
 tb/tb_tdm_mux41_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tdm_mux41_tx_if.sv
// Channel-side bundle of the TDM 4:1 transmitter: channel data, mask and
// enable in; serial line, select code and framing status out.
interface tdm_mux41_tx_if;
    logic       iEn;
    logic       iD0;
    logic       iD1;
    logic       iD2;
    logic       iD3;
    logic [3:0] iMask;
    logic       oC;
    logic       oS1;
    logic       oS0;
    logic       oFrame;
    logic       oBusy;

    modport slave (
        input  iEn, iD0, iD1, iD2, iD3, iMask,
        output oC, oS1, oS0, oFrame, oBusy
    );

    modport master (
        output iEn, iD0, iD1, iD2, iD3, iMask,
        input  oC, oS1, oS0, oFrame, oBusy
    );
endinterface

// File: rtl/tdm_mux41_tx.sv
// Time-division 4:1 transmitter: snapshots four channel bits per frame and
// serialises the enabled ones on oC with the matching select code on oS1/oS0.
module tdm_mux41_tx #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input logic           iClk,
    input logic           iRst_n,
    tdm_mux41_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SLOT} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [1:0]       chan, chanNext;
    logic [3:0]       shadowD, shadowMask;
    logic             firstSlot;
    logic [3:0]       liveD;
    logic             startOk;
    logic [2:0]       liveHit, nextHit;
    logic             cNext, s1Next, s0Next, frameNext, busyNext;
    logic             cReg, s1Reg, s0Reg, frameReg, busyReg;

    // Lowest set bit of mask at index >= start, returned as {found, index}.
    function automatic logic [2:0] firstFrom(input logic [3:0] mask, input int start);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i >= start && mask[i]) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    assign liveD   = {bus.iD3, bus.iD2, bus.iD1, bus.iD0};
    assign startOk = bus.iEn && (bus.iMask != 4'b0000);
    assign liveHit = firstFrom(bus.iMask, 0);
    assign nextHit = firstFrom(shadowMask, int'(chan) + 1);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            chan       <= 2'b00;
            shadowD    <= 4'b0000;
            shadowMask <= 4'b0000;
            firstSlot  <= 1'b0;
            cReg       <= 1'b1;
            s1Reg      <= 1'b0;
            s0Reg      <= 1'b0;
            frameReg   <= 1'b0;
            busyReg    <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            chan      <= chanNext;
            firstSlot <= (state == LOAD);
            if (state == LOAD) begin
                shadowD    <= liveD;
                shadowMask <= bus.iMask;
            end
            cReg     <= cNext;
            s1Reg    <= s1Next;
            s0Reg    <= s0Next;
            frameReg <= frameNext;
            busyReg  <= busyNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        chanNext  = chan;
        case (state)
            IDLE: begin
                if (startOk) stateNext = LOAD;
            end
            LOAD: begin
                cntNext = '0;
                // A mask that dropped to zero during LOAD leaves nothing to send.
                if (liveHit[2]) begin
                    stateNext = SLOT;
                    chanNext  = liveHit[1:0];
                end else begin
                    stateNext = IDLE;
                end
            end
            SLOT: begin
                if (cnt == LAST) begin
                    cntNext = '0;
                    if (nextHit[2])   chanNext  = nextHit[1:0];
                    else if (startOk) stateNext = LOAD;
                    else              stateNext = IDLE;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are decoded from the current state and registered, so the line
    // shows each state one cycle after the state register enters it.
    always_comb begin
        cNext     = 1'b1;
        s1Next    = 1'b0;
        s0Next    = 1'b0;
        frameNext = 1'b0;
        busyNext  = 1'b0;
        case (state)
            LOAD: busyNext = 1'b1;
            SLOT: begin
                busyNext  = 1'b1;
                cNext     = shadowD[chan];
                s1Next    = chan[1];
                s0Next    = chan[0];
                frameNext = firstSlot;
            end
            default: ;
        endcase
    end

    assign bus.oC     = cReg;
    assign bus.oS1    = s1Reg;
    assign bus.oS0    = s0Reg;
    assign bus.oFrame = frameReg;
    assign bus.oBusy  = busyReg;
endmodule

// File: tb/tb_tdm_mux41_tx.sv
// Bench for tdm_mux41_tx: DWELL=4 and DWELL=1 instances share stimulus and are
// checked every cycle against a frame-level queue model.
module tb_tdm_mux41_tx;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    tdm_mux41_tx_if busA();
    tdm_mux41_tx_if busB();

    tdm_mux41_tx #(.DWELL(4), .CNT_W(8)) dutA (.iClk(clk), .iRst_n(rstN), .bus(busA));
    tdm_mux41_tx #(.DWELL(1), .CNT_W(8)) dutB (.iClk(clk), .iRst_n(rstN), .bus(busB));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected output tuples {busy, frame, s1, s0, c}, one per future cycle.
    logic [4:0] expQ [2][$];
    logic       loadPend [2];
    int         dwell [2];
    int         frameCycA [$];

    logic       en;
    logic [3:0] dIn;
    logic [3:0] mask;

    localparam logic [4:0] IDLE_T = 5'b00001;
    localparam logic [4:0] LOAD_T = 5'b10001;

    task automatic checkEq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input logic e, input logic [3:0] d, input logic [3:0] m);
        en = e; dIn = d; mask = m;
        busA.iEn = e; busA.iMask = m;
        {busA.iD3, busA.iD2, busA.iD1, busA.iD0} = d;
        busB.iEn = e; busB.iMask = m;
        {busB.iD3, busB.iD2, busB.iD1, busB.iD0} = d;
    endtask

    // Frame-level model: at each edge, emit what the line shows next and
    // plan the whole frame at the edge that latches it.
    task automatic modelEdge(input int k, output logic [4:0] e);
        logic first;
        if (loadPend[k]) begin
            e = LOAD_T;
            loadPend[k] = 1'b0;
            first = 1'b1;
            for (int ch = 0; ch < 4; ch++) begin
                if (mask[ch]) begin
                    for (int r = 0; r < dwell[k]; r++) begin
                        expQ[k].push_back({1'b1, first, 2'(ch), dIn[ch]});
                        first = 1'b0;
                    end
                end
            end
        end else if (expQ[k].size() > 0) begin
            e = expQ[k].pop_front();
            if (expQ[k].size() == 0 && en && mask != 4'b0000) loadPend[k] = 1'b1;
        end else begin
            e = IDLE_T;
            if (en && mask != 4'b0000) loadPend[k] = 1'b1;
        end
    endtask

    function automatic logic [7:0] outsA();
        return {3'b000, busA.oBusy, busA.oFrame, busA.oS1, busA.oS0, busA.oC};
    endfunction

    function automatic logic [7:0] outsB();
        return {3'b000, busB.oBusy, busB.oFrame, busB.oS1, busB.oS0, busB.oC};
    endfunction

    task automatic step();
        logic [4:0] eA, eB;
        @(posedge clk);
        modelEdge(0, eA);
        modelEdge(1, eB);
        cyc++;
        #1;
        checkEq($sformatf("dwell4 cyc%0d", cyc), outsA(), {3'b000, eA});
        checkEq($sformatf("dwell1 cyc%0d", cyc), outsB(), {3'b000, eB});
        if (busA.oFrame) frameCycA.push_back(cyc);
    endtask

    // Asynchronous reset between edges; outputs must settle with no clock.
    task automatic doReset();
        rstN = 1'b0;
        #1;
        checkEq($sformatf("reset dwell4 cyc%0d", cyc), outsA(), {3'b000, IDLE_T});
        checkEq($sformatf("reset dwell1 cyc%0d", cyc), outsB(), {3'b000, IDLE_T});
        for (int k = 0; k < 2; k++) begin
            expQ[k].delete();
            loadPend[k] = 1'b0;
        end
        #1;
        rstN = 1'b1;
    endtask

    task automatic checkPeriod(input string tag, input int want);
        int n;
        int diff;
        n = frameCycA.size();
        checkEq({tag, " frames seen"}, 8'(n >= 2), 8'd1);
        diff = (n >= 2) ? frameCycA[n-1] - frameCycA[n-2] : 0;
        checkEq({tag, " period"}, 8'(diff), 8'(want));
    endtask

    initial begin
        int startCyc;
        dwell[0] = 4;
        dwell[1] = 1;
        loadPend[0] = 1'b0;
        loadPend[1] = 1'b0;
        setIn(1'b0, 4'b0000, 4'b0000);
        #12;
        checkEq("reset dwell4 initial", outsA(), {3'b000, IDLE_T});
        checkEq("reset dwell1 initial", outsB(), {3'b000, IDLE_T});
        rstN = 1'b1;
        repeat (3) step();

        // Alternating data on all four channels, full mask.
        frameCycA.delete();
        startCyc = cyc;
        setIn(1'b1, 4'b1010, 4'b1111);
        repeat (40) step();
        checkEq("first frame latency", 8'((frameCycA.size() > 0) ? frameCycA[0] - startCyc : 0), 8'd3);
        checkPeriod("mask1111", 17);

        // Sparse mask: only channels 0 and 2.
        setIn(1'b1, 4'b1010, 4'b0101);
        frameCycA.delete();
        repeat (45) step();
        checkPeriod("mask0101", 9);

        // Data and mask flip mid-frame take effect at the next LOAD only.
        doReset();
        setIn(1'b1, 4'b1010, 4'b1111);
        repeat (6) step();
        setIn(1'b1, 4'b1000, 4'b0011);
        repeat (30) step();

        // Enable dropped during the channel-1 slot: frame completes, then idle.
        doReset();
        setIn(1'b1, 4'b0110, 4'b1111);
        repeat (7) step();
        setIn(1'b0, 4'b0110, 4'b1111);
        repeat (25) step();
        checkEq("idle after enable drop", outsA(), {3'b000, IDLE_T});

        // Single-bit mask: one slot per frame.
        setIn(1'b1, 4'b1000, 4'b1000);
        frameCycA.delete();
        repeat (20) step();
        checkPeriod("mask1000", 5);

        // Zero mask never starts a frame.
        doReset();
        setIn(1'b1, 4'b1111, 4'b0000);
        repeat (50) step();

        // Randomized inputs with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            setIn($urandom_range(0, 7) != 0, 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 199) == 0) doReset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
